// File: rtl/serial_bus_pkg.sv
// Shared types and constants for the two-port serial IO bus arbiter.
package serial_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_STROBE = 3'd2,
    ST_HOLD   = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  localparam logic [15:0] BT_BASE_DEF   = 16'h0220;
  localparam logic [15:0] WIFI_BASE_DEF = 16'h0240;
  localparam int          CNT_W         = 4;

  // Phase length N is loaded as N-1; a zero length behaves as one cycle.
  function automatic logic [CNT_W-1:0] phase_load(input int n);
    if (n <= 1) return '0;
    return CNT_W'(n - 1);
  endfunction

endpackage

// File: rtl/serial_bus_timer.sv
// Loadable down-counter with zero flag; times the SETUP, STROBE and HOLD phases.
module serial_bus_timer
  import serial_bus_pkg::*;
(
  input  logic             Clock,
  input  logic             Reset_L,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge Clock or negedge Reset_L) begin
    if (!Reset_L) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/serial_bus_arbiter.sv
// Round-robin arbiter sharing the byte-wide serial IO bus between BT (port 0) and Wifi (port 1);
// access takes 1+SETUP+STROBE+HOLD+1 cycles. Optional port lock via SERIAL_ARB_LOCK_EN.
module serial_bus_arbiter
  import serial_bus_pkg::*;
#(
  parameter logic [15:0] BT_BASE       = BT_BASE_DEF,
  parameter logic [15:0] WIFI_BASE     = WIFI_BASE_DEF,
  parameter int          SETUP_CYCLES  = 1,
  parameter int          STROBE_CYCLES = 4,
  parameter int          HOLD_CYCLES   = 1
) (
  input  logic        Clock,
  input  logic        Reset_L,
  input  logic [1:0]  Req,
  input  logic [2:0]  RegIdx0,
  input  logic [2:0]  RegIdx1,
  input  logic        Write0,
  input  logic        Write1,
  input  logic [7:0]  WrData0,
  input  logic [7:0]  WrData1,
  input  logic [1:0]  Lock,
  output logic [1:0]  Grant,
  output logic [1:0]  Done,
  output logic [7:0]  RdData,
  output logic [15:0] Address,
  output logic        IOSelect_H,
  output logic        ByteSelect_L,
  output logic        WE_L,
  output logic [7:0]  DataOut,
  input  logic [7:0]  DataIn
);

  state_t           r_state;
  state_t           w_next;
  logic [1:0]       r_grant;
  logic             r_last;
  logic             r_write;
  logic [7:0]       r_wdata;
  logic [7:0]       r_rdata;
  logic [15:0]      r_addr;
  logic             w_zero;
  logic             w_load;
  logic [CNT_W-1:0] w_load_val;
  logic             w_win_vld;
  logic             w_win;
  logic             w_gport;
  logic             w_bus_act;
  logic [2:0]       w_idx;

  assign w_gport = r_grant[1];
  assign w_idx   = w_win ? RegIdx1 : RegIdx0;

`ifdef SERIAL_ARB_LOCK_EN
  logic r_lock_vld;
  logic r_lock_port;
  logic w_lock_hold;
  assign w_lock_hold = r_lock_vld && Lock[r_lock_port];
`else
  logic w_unused_lock;
  assign w_unused_lock = ^Lock;
`endif

  always_comb begin
    w_win_vld = 1'b0;
    w_win     = 1'b0;
    case (Req)
      2'b01:   begin w_win_vld = 1'b1; w_win = 1'b0;    end
      2'b10:   begin w_win_vld = 1'b1; w_win = 1'b1;    end
      2'b11:   begin w_win_vld = 1'b1; w_win = ~r_last; end
      default: ;
    endcase
`ifdef SERIAL_ARB_LOCK_EN
    // A held lock shuts out the other port; an idle locked port grants nobody this cycle.
    if (w_lock_hold) begin
      w_win_vld = Req[r_lock_port];
      w_win     = r_lock_port;
    end
`endif
  end

  always_comb begin
    w_next     = r_state;
    w_load     = 1'b0;
    w_load_val = '0;
    case (r_state)
      ST_IDLE: if (w_win_vld) begin
        w_next     = ST_SETUP;
        w_load     = 1'b1;
        w_load_val = phase_load(SETUP_CYCLES);
      end
      ST_SETUP: if (w_zero) begin
        w_next     = ST_STROBE;
        w_load     = 1'b1;
        w_load_val = phase_load(STROBE_CYCLES);
      end
      ST_STROBE: if (w_zero) begin
        w_next     = ST_HOLD;
        w_load     = 1'b1;
        w_load_val = phase_load(HOLD_CYCLES);
      end
      ST_HOLD: if (w_zero) w_next = ST_DONE;
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  serial_bus_timer u_timer (
    .Clock      (Clock),
    .Reset_L    (Reset_L),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_zero     (w_zero)
  );

  always_ff @(posedge Clock or negedge Reset_L) begin
    if (!Reset_L) begin
      r_state <= ST_IDLE;
      r_grant <= 2'b00;
      r_last  <= 1'b1;
      r_write <= 1'b0;
      r_wdata <= 8'h00;
      r_rdata <= 8'h00;
      r_addr  <= 16'h0000;
    end else begin
      r_state <= w_next;
      if (r_state == ST_IDLE && w_win_vld) begin
        r_grant <= w_win ? 2'b10 : 2'b01;
        r_write <= w_win ? Write1 : Write0;
        r_wdata <= w_win ? WrData1 : WrData0;
        r_addr  <= (w_win ? WIFI_BASE : BT_BASE) + {12'd0, w_idx, 1'b0};
      end
      if (r_state == ST_STROBE && w_zero && !r_write) r_rdata <= DataIn;
      if (r_state == ST_DONE) begin
        r_grant <= 2'b00;
`ifdef SERIAL_ARB_LOCK_EN
        if (!Lock[w_gport]) r_last <= w_gport;
`else
        r_last <= w_gport;
`endif
      end
    end
  end

`ifdef SERIAL_ARB_LOCK_EN
  always_ff @(posedge Clock or negedge Reset_L) begin
    if (!Reset_L) begin
      r_lock_vld  <= 1'b0;
      r_lock_port <= 1'b0;
    end else if (r_state == ST_DONE) begin
      r_lock_vld  <= Lock[w_gport];
      r_lock_port <= w_gport;
    end else if (r_state == ST_IDLE && r_lock_vld && !(Lock[r_lock_port] && Req[r_lock_port])) begin
      r_lock_vld <= 1'b0;
    end
  end
`endif

  assign w_bus_act    = (r_state == ST_SETUP) || (r_state == ST_STROBE) || (r_state == ST_HOLD);
  assign Grant        = r_grant;
  assign Done         = (r_state == ST_DONE) ? r_grant : 2'b00;
  assign RdData       = r_rdata;
  assign Address      = r_addr;
  assign IOSelect_H   = w_bus_act;
  assign ByteSelect_L = ~w_bus_act;
  assign WE_L         = ~((r_state == ST_STROBE) && r_write);
  assign DataOut      = (w_bus_act && r_write) ? r_wdata : 8'h00;

endmodule

// File: tb/tb_serial_bus_arbiter.sv
// Self-checking bench for serial_bus_arbiter: directed scenarios plus a Done scoreboard.
module tb_serial_bus_arbiter;

  logic        Clock = 1'b0;
  logic        Reset_L;
  logic [1:0]  Req, Req2, Lock;
  logic [2:0]  RegIdx0, RegIdx1;
  logic        Write0, Write1;
  logic [7:0]  WrData0, WrData1, DataIn;
  logic [1:0]  Grant, Done, Grant2, Done2;
  logic [7:0]  RdData, DataOut, RdData2, DataOut2;
  logic [15:0] Address, Address2;
  logic        IOSelect_H, ByteSelect_L, WE_L, IOSelect_H2, ByteSelect_L2, WE_L2;

  typedef struct packed {
    logic [1:0] done;
    logic       rd;
    logic [7:0] data;
  } exp_t;

  exp_t sb_q[$];
  exp_t sb_e;
  int   tests = 0;
  int   fails = 0;

  always #5 Clock = ~Clock;

  serial_bus_arbiter dut (
    .Clock(Clock), .Reset_L(Reset_L), .Req(Req), .RegIdx0(RegIdx0), .RegIdx1(RegIdx1),
    .Write0(Write0), .Write1(Write1), .WrData0(WrData0), .WrData1(WrData1), .Lock(Lock),
    .Grant(Grant), .Done(Done), .RdData(RdData), .Address(Address), .IOSelect_H(IOSelect_H),
    .ByteSelect_L(ByteSelect_L), .WE_L(WE_L), .DataOut(DataOut), .DataIn(DataIn)
  );

  serial_bus_arbiter #(.SETUP_CYCLES(2), .STROBE_CYCLES(3), .HOLD_CYCLES(2)) dut2 (
    .Clock(Clock), .Reset_L(Reset_L), .Req(Req2), .RegIdx0(RegIdx0), .RegIdx1(RegIdx1),
    .Write0(Write0), .Write1(Write1), .WrData0(WrData0), .WrData1(WrData1), .Lock(Lock),
    .Grant(Grant2), .Done(Done2), .RdData(RdData2), .Address(Address2), .IOSelect_H(IOSelect_H2),
    .ByteSelect_L(ByteSelect_L2), .WE_L(WE_L2), .DataOut(DataOut2), .DataIn(DataIn)
  );

  // Scoreboard: every Done pulse must match the oldest outstanding expectation.
  always @(negedge Clock) begin
    if (Reset_L === 1'b1) begin
      tests++;
      if (!$onehot0(Grant)) begin
        fails++;
        $display("FAIL grant_onehot: Grant=%b required one-hot or zero", Grant);
      end
      if (Done !== 2'b00) begin
        tests++;
        if (sb_q.size() == 0) begin
          fails++;
          $display("FAIL sb_unexpected_done: Done=%b required no pulse", Done);
        end else begin
          sb_e = sb_q.pop_front();
          if (Done !== sb_e.done) begin
            fails++;
            $display("FAIL sb_done: Done=%b required %b", Done, sb_e.done);
          end
          if (sb_e.rd) begin
            tests++;
            if (RdData !== sb_e.data) begin
              fails++;
              $display("FAIL sb_rddata: RdData=%h required %h", RdData, sb_e.data);
            end
          end
        end
      end
    end
  end

  task automatic wait_done(input int budget, output logic [1:0] d, output int cyc);
    bit seen;
    seen = 1'b0;
    d    = 2'b00;
    cyc  = 0;
    for (int i = 1; i <= budget && !seen; i++) begin
      @(negedge Clock);
      if (Done !== 2'b00) begin
        d    = Done;
        cyc  = i;
        seen = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge Clock);
    tests++;
    if ({Grant, Done, RdData, Address, DataOut} !== 36'd0) begin
      fails++;
      $display("FAIL reset_zero_outs: G=%b D=%b Rd=%h A=%h DO=%h required all zero",
               Grant, Done, RdData, Address, DataOut);
    end
    tests++;
    if ({IOSelect_H, ByteSelect_L, WE_L} !== 3'b011) begin
      fails++;
      $display("FAIL reset_bus_ctl: IOSel/BS_L/WE_L=%b required 011", {IOSelect_H, ByteSelect_L, WE_L});
    end
    Reset_L = 1'b1;
    @(negedge Clock);
  endtask

  task automatic test_write();
    RegIdx0 = 3'd3; Write0 = 1'b1; WrData0 = 8'hA5; Req = 2'b01;
    sb_q.push_back('{done: 2'b01, rd: 1'b0, data: 8'h00});
    for (int k = 1; k <= 8; k++) begin
      @(negedge Clock);
      if (k <= 6) begin
        tests++;
        if (Address !== 16'h0226 || DataOut !== 8'hA5 || IOSelect_H !== 1'b1 || ByteSelect_L !== 1'b0) begin
          fails++;
          $display("FAIL wr_bus c%0d: A=%h DO=%h IOS=%b BS_L=%b required 0226 A5 1 0",
                   k, Address, DataOut, IOSelect_H, ByteSelect_L);
        end
      end else begin
        tests++;
        if (IOSelect_H !== 1'b0 || ByteSelect_L !== 1'b1) begin
          fails++;
          $display("FAIL wr_idle c%0d: IOS=%b BS_L=%b required 0 1", k, IOSelect_H, ByteSelect_L);
        end
      end
      tests++;
      if (WE_L !== ((k >= 2 && k <= 5) ? 1'b0 : 1'b1)) begin
        fails++;
        $display("FAIL wr_we c%0d: WE_L=%b required %b", k, WE_L, (k >= 2 && k <= 5) ? 1'b0 : 1'b1);
      end
      tests++;
      if (Done !== ((k == 7) ? 2'b01 : 2'b00)) begin
        fails++;
        $display("FAIL wr_done c%0d: Done=%b required %b", k, Done, (k == 7) ? 2'b01 : 2'b00);
      end
      if (k == 7) Req = 2'b00;
    end
  endtask

  task automatic test_read();
    RegIdx1 = 3'd5; Write1 = 1'b0; DataIn = 8'h3C; Req = 2'b10;
    sb_q.push_back('{done: 2'b10, rd: 1'b1, data: 8'h3C});
    for (int k = 1; k <= 8; k++) begin
      @(negedge Clock);
      if (k <= 6) begin
        tests++;
        if (Address !== 16'h024A || DataOut !== 8'h00 || Grant !== 2'b10) begin
          fails++;
          $display("FAIL rd_bus c%0d: A=%h DO=%h G=%b required 024A 00 10", k, Address, DataOut, Grant);
        end
      end
      if (k == 6) DataIn = 8'hFF;
      tests++;
      if (WE_L !== 1'b1) begin
        fails++;
        $display("FAIL rd_we c%0d: WE_L=%b required 1", k, WE_L);
      end
      if (k == 7) begin
        tests++;
        if (Done !== 2'b10 || RdData !== 8'h3C) begin
          fails++;
          $display("FAIL rd_done: Done=%b RdData=%h required 10 3C", Done, RdData);
        end
        Req = 2'b00;
      end
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] d, exp_d;
    int         cyc;
    Write0 = 1'b0; Write1 = 1'b0; DataIn = 8'h5A; Req = 2'b11;
    for (int n = 0; n < 4; n++)
      sb_q.push_back('{done: (n % 2 == 0) ? 2'b01 : 2'b10, rd: 1'b1, data: 8'h5A});
    for (int n = 0; n < 4; n++) begin
      exp_d = (n % 2 == 0) ? 2'b01 : 2'b10;
      wait_done(20, d, cyc);
      tests++;
      if (d !== exp_d || cyc != 7) begin
        fails++;
        $display("FAIL rr_grant n%0d: Done=%b after %0d cycles required %b after 7", n, d, cyc, exp_d);
      end
      if (n == 3) Req = 2'b00;
      @(negedge Clock);
      tests++;
      if (Done !== 2'b00) begin
        fails++;
        $display("FAIL rr_pulse_width n%0d: Done=%b required 00", n, Done);
      end
    end
  endtask

  task automatic test_reset_mid_access();
    logic [1:0] d;
    int         cyc;
    Write0 = 1'b0; Req = 2'b01;
    sb_q.push_back('{done: 2'b01, rd: 1'b1, data: 8'h5A});
    wait_done(20, d, cyc);
    tests++;
    if (d !== 2'b01) begin
      fails++;
      $display("FAIL rst_pre_access: Done=%b required 01", d);
    end
    Req = 2'b00;
    @(negedge Clock);
    RegIdx1 = 3'd2; Write1 = 1'b1; WrData1 = 8'hC3; Req = 2'b10;
    repeat (3) @(negedge Clock);
    tests++;
    if (WE_L !== 1'b0) begin
      fails++;
      $display("FAIL rst_in_strobe: WE_L=%b required 0", WE_L);
    end
    Reset_L = 1'b0;
    #1;
    tests++;
    if ({WE_L, IOSelect_H, ByteSelect_L, Grant} !== 5'b10100) begin
      fails++;
      $display("FAIL rst_async_release: WE_L/IOS/BS_L/Grant=%b required 10100",
               {WE_L, IOSelect_H, ByteSelect_L, Grant});
    end
    Req = 2'b00;
    for (int k = 0; k < 3; k++) begin
      @(negedge Clock);
      tests++;
      if (Done !== 2'b00) begin
        fails++;
        $display("FAIL rst_no_done c%0d: Done=%b required 00", k, Done);
      end
    end
    Reset_L = 1'b1;
    @(negedge Clock);
    Write0 = 1'b0; Req = 2'b11;
    sb_q.push_back('{done: 2'b01, rd: 1'b1, data: 8'h5A});
    wait_done(20, d, cyc);
    tests++;
    if (d !== 2'b01) begin
      fails++;
      $display("FAIL rst_first_tie: Done=%b required 01", d);
    end
    Req = 2'b00;
    @(negedge Clock);
  endtask

  task automatic test_timing();
    logic we_exp;
    RegIdx0 = 3'd1; Write0 = 1'b1; WrData0 = 8'h77; Req2 = 2'b01;
    for (int k = 1; k <= 10; k++) begin
      @(negedge Clock);
      we_exp = (k >= 3 && k <= 5) ? 1'b0 : 1'b1;
      tests++;
      if (WE_L2 !== we_exp) begin
        fails++;
        $display("FAIL timing_we c%0d: WE_L=%b required %b", k, WE_L2, we_exp);
      end
      tests++;
      if (Done2 !== ((k == 8) ? 2'b01 : 2'b00)) begin
        fails++;
        $display("FAIL timing_done c%0d: Done=%b required %b", k, Done2, (k == 8) ? 2'b01 : 2'b00);
      end
      if (k == 8) Req2 = 2'b00;
    end
  endtask

  task automatic test_lock();
    logic [1:0] d;
    logic [1:0] exp_d [4];
    int         cyc;
    int         n_acc;
    Write0 = 1'b0; Write1 = 1'b0; DataIn = 8'h5A; Lock = 2'b01;
`ifdef SERIAL_ARB_LOCK_EN
    exp_d = '{2'b01, 2'b01, 2'b01, 2'b10};
    n_acc = 4;
    Req   = 2'b01;
`else
    exp_d = '{2'b10, 2'b01, 2'b10, 2'b00};
    n_acc = 3;
    Req   = 2'b11;
`endif
    for (int n = 0; n < n_acc; n++)
      sb_q.push_back('{done: exp_d[n], rd: 1'b1, data: 8'h5A});
    for (int n = 0; n < n_acc; n++) begin
      wait_done(20, d, cyc);
      tests++;
      if (d !== exp_d[n]) begin
        fails++;
        $display("FAIL lock_seq n%0d: Done=%b required %b", n, d, exp_d[n]);
      end
      Req = 2'b11;
      if (n == 2) Lock = 2'b00;
      if (n == n_acc - 1) Req = 2'b00;
    end
    Lock = 2'b00;
    @(negedge Clock);
  endtask

  initial begin
    Reset_L = 1'b0; Req = 2'b00; Req2 = 2'b00; Lock = 2'b00;
    RegIdx0 = 3'd0; RegIdx1 = 3'd0; Write0 = 1'b0; Write1 = 1'b0;
    WrData0 = 8'h00; WrData1 = 8'h00; DataIn = 8'hFF;
    test_reset();
    test_write();
    test_read();
    test_round_robin();
    test_reset_mid_access();
    test_timing();
    test_lock();
    repeat (3) @(negedge Clock);
    tests++;
    if (sb_q.size() != 0) begin
      fails++;
      $display("FAIL sb_leftover: %0d outstanding expectations required 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
